// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the stopwatch control sequencer:
//   state_t      : run/pause/adjust state enumeration
//   bcd_t        : one 4-bit BCD digit
//   DEF_MAX_MIN  : default highest minute value before wrap
//   DEF_MAX_SEC  : default highest second value before wrap
//   BLANK_*      : blank masks, bit order {min_tens, min_ones, sec_tens, sec_ones}
//   to_bcd8()    : converts a 0..99 integer into two packed BCD digits
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSE  = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int DEF_MAX_MIN = 99;
  localparam int DEF_MAX_SEC = 59;

  localparam logic [3:0] BLANK_NONE = 4'b0000;
  localparam logic [3:0] BLANK_MIN  = 4'b1100;
  localparam logic [3:0] BLANK_SEC  = 4'b0011;

  // Used at elaboration time to turn the integer limits into the BCD
  // compare values the counters work with.
  function automatic logic [7:0] to_bcd8(input int value);
    return {4'(value / 10), 4'(value % 10)};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// -----------------------------------------------------------------------------
// bcd2_counter
// Two-digit BCD up-counter that wraps from a programmable maximum back to 00.
// Ports:
//   i_sclk   in  1  system clock
//   i_rst    in  1  synchronous active-high reset (digits -> 00)
//   i_clr    in  1  synchronous clear (digits -> 00), wins over i_inc
//   i_inc    in  1  increment by one this cycle
//   i_max    in  8  wrap value as packed BCD {tens, ones}
//   o_tens   out 4  tens digit (registered)
//   o_ones   out 4  ones digit (registered)
//   o_wrap   out 1  high in the cycle an increment wraps max -> 00
// -----------------------------------------------------------------------------
module bcd2_counter
  import stopwatch_pkg::*;
(
  input  logic       i_sclk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_inc,
  input  logic [7:0] i_max,
  output bcd_t       o_tens,
  output bcd_t       o_ones,
  output logic       o_wrap
);

  bcd_t r_tens;
  bcd_t r_ones;
  logic w_atMax;

  assign w_atMax = ({r_tens, r_ones} == i_max);

  // The wrap pulse is combinational so the next counter in the chain can
  // take its carry in the same clock edge as this counter rolls over.
  assign o_wrap = i_inc & ~i_clr & w_atMax;

  // BCD increment: ones 9 -> 0 carries into tens; reaching the maximum
  // returns both digits to zero.
  always_ff @(posedge i_sclk) begin
    if (i_rst || i_clr) begin
      r_tens <= '0;
      r_ones <= '0;
    end else if (i_inc) begin
      if (w_atMax) begin
        r_tens <= '0;
        r_ones <= '0;
      end else if (r_ones == 4'd9) begin
        r_ones <= '0;
        r_tens <= r_tens + 4'd1;
      end else begin
        r_ones <= r_ones + 4'd1;
      end
    end
  end

  assign o_tens = r_tens;
  assign o_ones = r_ones;

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Run/pause/adjust sequencer for the stopwatch. Keeps MM:SS as four BCD digits
// and drives the digit/blank inputs of the 7-segment multiplexer.
// Optional feature macro: STOPWATCH_LAP_EN (lap freeze of the displayed time).
// Ports:
//   sclk      in  1  system clock
//   rst       in  1  synchronous active-high reset
//   tick_1hz  in  1  count tick (RUN)
//   tick_2hz  in  1  adjust/blink tick (ADJUST)
//   pause_p   in  1  toggles RUN/PAUSE
//   clr_p     in  1  clears the time to 00:00, state unchanged
//   adj       in  1  level, 1 = adjust mode
//   sel       in  1  level, adjust field: 0 = minutes, 1 = seconds
//   lap_p     in  1  lap hold toggle (only with STOPWATCH_LAP_EN)
//   min_tens, min_ones, sec_tens, sec_ones  out 4 each  display digits
//   blank     out 4  per-digit blank mask {min_tens, min_ones, sec_tens, sec_ones}
//   running   out 1  high while in RUN
// -----------------------------------------------------------------------------
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = DEF_MAX_MIN,
  parameter int MAX_SEC = DEF_MAX_SEC
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause_p,
  input  logic       clr_p,
  input  logic       adj,
  input  logic       sel,
  input  logic       lap_p,
  output bcd_t       min_tens,
  output bcd_t       min_ones,
  output bcd_t       sec_tens,
  output bcd_t       sec_ones,
  output logic [3:0] blank,
  output logic       running
);

  localparam logic [7:0] MAX_MIN_BCD = to_bcd8(MAX_MIN);
  localparam logic [7:0] MAX_SEC_BCD = to_bcd8(MAX_SEC);

  state_t      r_state;
  state_t      w_nextState;
  logic        r_blink;
  logic        w_nextBlink;
  logic [3:0]  r_blank;
  logic [3:0]  w_nextBlank;
  logic        r_running;

  logic        w_runCount;
  logic        w_adjTick;
  logic        w_secInc;
  logic        w_minInc;
  logic        w_secWrap;
  logic        w_minWrap;
  logic [15:0] w_liveTime;
  logic [15:0] w_dispTime;

  // A clear or an adjust request outranks a tick, so the tick is dropped.
  // pause_p does not block the count tick: it is still counted on the way
  // out of RUN.
  assign w_runCount = (r_state == RUN) & tick_1hz & ~clr_p & ~adj;
  assign w_adjTick  = (r_state == ADJUST) & tick_2hz & ~clr_p & adj;

  // Seconds carry into minutes only while counting; in ADJUST each field
  // wraps on its own.
  assign w_secInc = w_runCount | (w_adjTick & sel);
  assign w_minInc = (w_runCount & w_secWrap) | (w_adjTick & ~sel);

  bcd2_counter u_sec (
    .i_sclk (sclk),
    .i_rst  (rst),
    .i_clr  (clr_p),
    .i_inc  (w_secInc),
    .i_max  (MAX_SEC_BCD),
    .o_tens (w_liveTime[7:4]),
    .o_ones (w_liveTime[3:0]),
    .o_wrap (w_secWrap)
  );

  bcd2_counter u_min (
    .i_sclk (sclk),
    .i_rst  (rst),
    .i_clr  (clr_p),
    .i_inc  (w_minInc),
    .i_max  (MAX_MIN_BCD),
    .o_tens (w_liveTime[15:12]),
    .o_ones (w_liveTime[11:8]),
    .o_wrap (w_minWrap)
  );

  // Next state, blink phase and blank mask. clr_p freezes the state machine
  // for the cycle; adj wins over pause_p; dropping adj always lands in PAUSE.
  always_comb begin
    w_nextState = r_state;
    w_nextBlink = r_blink;
    if (!clr_p) begin
      if (adj) begin
        w_nextState = ADJUST;
      end else if (r_state == ADJUST) begin
        w_nextState = PAUSE;
      end else if (pause_p) begin
        w_nextState = (r_state == RUN) ? PAUSE : RUN;
      end

      if (w_adjTick) begin
        w_nextBlink = ~r_blink;
      end else if ((r_state == ADJUST) && !adj) begin
        w_nextBlink = 1'b0;
      end
    end

    w_nextBlank = BLANK_NONE;
    if ((w_nextState == ADJUST) && w_nextBlink) begin
      w_nextBlank = sel ? BLANK_SEC : BLANK_MIN;
    end
  end

  // State register plus the registered running/blank outputs.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state   <= PAUSE;
      r_blink   <= 1'b0;
      r_blank   <= BLANK_NONE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_blink   <= w_nextBlink;
      r_blank   <= w_nextBlank;
      r_running <= (w_nextState == RUN);
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        r_lapHold;
  logic [15:0] r_lapTime;
  logic        w_unusedMinWrap;

  assign w_unusedMinWrap = w_minWrap;

  // Lap hold: the first lap_p in RUN captures the time as it stands before
  // this cycle's tick; the next lap_p, leaving RUN or a clear releases it.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_lapHold <= 1'b0;
      r_lapTime <= '0;
    end else if (clr_p || (w_nextState != RUN)) begin
      r_lapHold <= 1'b0;
    end else if (lap_p && (r_state == RUN)) begin
      r_lapHold <= ~r_lapHold;
      if (!r_lapHold) begin
        r_lapTime <= w_liveTime;
      end
    end
  end

  assign w_dispTime = r_lapHold ? r_lapTime : w_liveTime;
`else
  logic w_unusedLap;

  assign w_unusedLap = lap_p ^ w_minWrap;
  assign w_dispTime  = w_liveTime;
`endif

  assign {min_tens, min_ones, sec_tens, sec_ones} = w_dispTime;
  assign blank   = r_blank;
  assign running = r_running;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Self-checking bench for stopwatch_ctrl. Keeps a behavioural model that holds
// the time as integer minutes/seconds and the mode as a small integer, then
// compares every cycle. Directed scenarios are followed by a random phase.
// Honours STOPWATCH_LAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int MAXM = 99;
  localparam int MAXS = 59;
  localparam int M_PAUSE = 0;
  localparam int M_RUN   = 1;
  localparam int M_ADJ   = 2;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       sclk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic       pause_p = 1'b0;
  logic       clr_p = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic       lap_p = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [3:0] blank;
  logic       running;
  logic [15:0] dispTime;

  int checks = 0;
  int failures = 0;

  int mMin = 0, mSec = 0, mMode = M_PAUSE;
  bit mBlink = 1'b0, mLapHold = 1'b0;
  int mLapMin = 0, mLapSec = 0;

  stopwatch_ctrl dut (
    .sclk     (sclk),
    .rst      (rst),
    .tick_1hz (tick_1hz),
    .tick_2hz (tick_2hz),
    .pause_p  (pause_p),
    .clr_p    (clr_p),
    .adj      (adj),
    .sel      (sel),
    .lap_p    (lap_p),
    .min_tens (min_tens),
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .blank    (blank),
    .running  (running)
  );

  assign dispTime = {min_tens, min_ones, sec_tens, sec_ones};

  always #5 sclk = ~sclk;

  function automatic logic [15:0] bcdTime(input int mn, input int sc);
    return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  // Single comparison point: counts every check, reports each mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference behaviour for one clock edge, using the inputs being sampled.
  task automatic modelStep(input bit r, input bit t1, input bit t2,
                           input bit pp, input bit cp, input bit lp);
    int nextMode;
    int total;
    if (r) begin
      mMin = 0; mSec = 0; mMode = M_PAUSE; mBlink = 0; mLapHold = 0;
    end else if (cp) begin
      mMin = 0; mSec = 0; mLapHold = 0;
    end else begin
      if (adj) nextMode = M_ADJ;
      else if (mMode == M_ADJ) nextMode = M_PAUSE;
      else if (pp) nextMode = (mMode == M_RUN) ? M_PAUSE : M_RUN;
      else nextMode = mMode;

      if (LAP_EN) begin
        if (nextMode != M_RUN) mLapHold = 0;
        else if (lp && mMode == M_RUN) begin
          if (!mLapHold) begin mLapMin = mMin; mLapSec = mSec; end
          mLapHold = !mLapHold;
        end
      end

      if (mMode == M_RUN && t1 && !adj) begin
        total = (mMin * (MAXS + 1) + mSec + 1) % ((MAXM + 1) * (MAXS + 1));
        mMin = total / (MAXS + 1);
        mSec = total % (MAXS + 1);
      end

      if (mMode == M_ADJ && adj && t2) begin
        if (sel) mSec = (mSec + 1) % (MAXS + 1);
        else     mMin = (mMin + 1) % (MAXM + 1);
        mBlink = !mBlink;
      end else if (mMode == M_ADJ && !adj) begin
        mBlink = 0;
      end
      mMode = nextMode;
    end
  endtask

  // Drive one cycle of pulses, advance the model, then compare all outputs
  // one time unit after the edge.
  task automatic applyStimulus(input bit r, input bit t1, input bit t2,
                               input bit pp, input bit cp, input bit lp);
    logic [15:0] expTime;
    logic [3:0]  expBlank;
    rst = r; tick_1hz = t1; tick_2hz = t2; pause_p = pp; clr_p = cp; lap_p = lp;
    @(posedge sclk);
    modelStep(r, t1, t2, pp, cp, lp);
    #1;
    rst = 0; tick_1hz = 0; tick_2hz = 0; pause_p = 0; clr_p = 0; lap_p = 0;
    expTime  = (LAP_EN && mLapHold) ? bcdTime(mLapMin, mLapSec) : bcdTime(mMin, mSec);
    expBlank = (mMode == M_ADJ && mBlink) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
    checkOutput("digits", 32'(dispTime), 32'(expTime));
    checkOutput("blank", 32'(blank), 32'(expBlank));
    checkOutput("running", 32'(running), 32'(mMode == M_RUN));
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic count1(input int n);
    repeat (n) begin
      applyStimulus(0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic count2(input int n);
    repeat (n) begin
      applyStimulus(0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    // Reset and first counting run.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset_time", 32'(dispTime), 32'h0000);
    checkOutput("reset_blank", 32'(blank), 32'h0);
    checkOutput("reset_running", 32'(running), 32'h0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    count1(61);
    checkOutput("run_0101", 32'(dispTime), 32'h0101);
    checkOutput("run_running", 32'(running), 32'h1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    count1(5);
    checkOutput("pause_0101", 32'(dispTime), 32'h0101);
    checkOutput("pause_running", 32'(running), 32'h0);

    // Preload 99:59 through ADJUST, then roll over in RUN.
    adj = 1; sel = 0;
    idle(1);
    count2(98);
    sel = 1;
    count2(58);
    adj = 0;
    idle(1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("preload_9959", 32'(dispTime), 32'h9959);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("rollover_0000", 32'(dispTime), 32'h0000);

    // Seconds adjust wraps without minute carry; blank follows blink phase.
    applyStimulus(0, 0, 0, 0, 1, 0);
    count1(58);
    applyStimulus(0, 0, 0, 1, 0, 0);
    adj = 1; sel = 1;
    idle(1);
    checkOutput("adj_blank0", 32'(blank), 32'h0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("adj_0059", 32'(dispTime), 32'h0059);
    checkOutput("adj_blank1", 32'(blank), 32'h3);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("adj_wrap", 32'(dispTime), 32'h0000);
    checkOutput("adj_blank2", 32'(blank), 32'h0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    checkOutput("adj_0001", 32'(dispTime), 32'h0001);
    checkOutput("adj_blank3", 32'(blank), 32'h3);
    adj = 0;
    idle(1);
    checkOutput("adj_exit_blank", 32'(blank), 32'h0);
    checkOutput("adj_exit_running", 32'(running), 32'h0);

    // Same-cycle priorities.
    applyStimulus(0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    count1(10);
    applyStimulus(0, 1, 0, 1, 0, 0);
    checkOutput("tick_pause_0011", 32'(dispTime), 32'h0011);
    checkOutput("tick_pause_running", 32'(running), 32'h0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 0);
    checkOutput("tick_clr_0000", 32'(dispTime), 32'h0000);
    checkOutput("tick_clr_running", 32'(running), 32'h1);

    // Reset in mid-count at 12:34.
    applyStimulus(0, 0, 0, 1, 0, 0);
    adj = 1; sel = 0;
    idle(1);
    count2(12);
    sel = 1;
    count2(34);
    adj = 0;
    idle(1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("pre_rst_1234", 32'(dispTime), 32'h1234);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("rst_time", 32'(dispTime), 32'h0000);
    checkOutput("rst_running", 32'(running), 32'h0);
    checkOutput("rst_blank", 32'(blank), 32'h0);

    // Lap hold, when built in.
    if (LAP_EN) begin
      applyStimulus(0, 0, 0, 1, 0, 0);
      count1(5);
      applyStimulus(0, 0, 0, 0, 0, 1);
      count1(10);
      checkOutput("lap_hold_0005", 32'(dispTime), 32'h0005);
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("lap_release_0015", 32'(dispTime), 32'h0015);
    end

    // Random phase against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) adj = ~adj;
      if ($urandom_range(0, 9) == 0) sel = ~sel;
      applyStimulus($urandom_range(0, 299) == 0,
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 99) == 0,
                    $urandom_range(0, 11) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control sequencer for the stopwatch. It consumes the one-cycle tick pulses produced by the clock divider (1 Hz count tick, 2 Hz adjust/blink tick) and the debounced button pulses. It runs a run/pause/adjust state machine and maintains the MM:SS time as four BCD digits. Its digit and blank outputs feed the 7-segment display multiplexer, which is clocked from the divider's 400 Hz output.

## Interface
Parameters:
- MAX_MIN, 99, highest minute value before wrap (BCD 00–99)
- MAX_SEC, 59, highest second value before wrap

Ports:
- sclk  in  1  system clock (100 MHz)
- rst  in  1  reset; synchronous, active-high
- tick_1hz  in  1  one-cycle pulse, 1 Hz count tick
- tick_2hz  in  1  one-cycle pulse, 2 Hz adjust/blink tick
- pause_p  in  1  one-cycle debounced pulse; toggles run/pause
- clr_p  in  1  one-cycle debounced pulse; clears time to 00:00
- adj  in  1  level; 1 = adjust mode
- sel  in  1  level; adjust field select, 0 = minutes, 1 = seconds
- lap_p  in  1  one-cycle pulse; lap freeze toggle (see Configuration)
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD display digits
- blank  out  4  per-digit blank mask [3:0] = {min_tens, min_ones, sec_tens, sec_ones}
- running  out  1  1 while in RUN

## Operation
- States: PAUSE, RUN, ADJUST.
- Reset state is PAUSE with time 00:00, blink phase 0, blank 0000, running 0.
- PAUSE: pause_p goes to RUN. adj=1 goes to ADJUST.
- RUN: tick_1hz increments the time. pause_p goes to PAUSE. adj=1 goes to ADJUST.
- ADJUST:
  - tick_2hz increments only the field chosen by sel. Seconds wrap 59→00 with no carry. Minutes wrap 99→00.
  - tick_2hz also toggles the blink phase. While the phase is 1, the selected digit pair is blanked (blank = 1100 for minutes, 0011 for seconds).
  - adj=0 goes to PAUSE and clears the blink phase.
- Count increment (RUN only):
  - sec < MAX_SEC: sec+1.
  - sec = MAX_SEC: sec→00 and minutes+1.
  - MAX_MIN:MAX_SEC rolls over to 00:00.
  - All arithmetic is in BCD: a ones digit of 9 wraps to 0 and carries into the tens digit.
- clr_p sets the time to 00:00 in any state. The state does not change.
- Per-cycle priority: rst > clr_p > adj > pause_p > ticks.
  - tick_1hz in the same cycle as pause_p in RUN: the tick is counted and the state still goes to PAUSE.
  - A tick in the same cycle as clr_p is dropped.
- Inputs outside the stated encodings do not occur: BCD digits never leave their legal range.

## Timing
- All outputs are registered.
- A tick sampled in cycle N is visible on the digit outputs in cycle N+1.
- State changes on pause_p or adj are reflected on running and blank in N+1.
- rst asserted in mid-count forces the reset values in the next cycle. Any partial carry is discarded.
- The tick inputs are assumed synchronous to sclk and at most one cycle wide. A multi-cycle tick counts once per asserted cycle.

## Configuration
- STOPWATCH_LAP_EN defined:
  - A lap display register is added.
  - lap_p in RUN toggles lap hold. While held, the digit outputs show the time captured when lap_p arrived, and internal counting continues.
  - Hold is released by a second lap_p, by leaving RUN, or by clr_p or rst.
- STOPWATCH_LAP_EN undefined:
  - lap_p is ignored and no lap register exists.
  - The digit outputs always show the live time.

## Structure
- Package stopwatch_pkg holds:
  - the state enumeration (PAUSE, RUN, ADJUST)
  - the 4-bit BCD digit type
  - the default MAX_MIN and MAX_SEC constants
  - the blank-mask constants for the minutes and seconds pairs
- Sub-module bcd2_counter is a two-digit BCD counter.
  - Inputs: inc, clr, max; outputs: the two digits and a wrap pulse.
  - It is instantiated twice, for seconds and minutes. The seconds wrap pulse is gated by state to drive the minutes inc.

## Test plan
- Reset, pause_p, then 61 tick_1hz → 01:01, running=1; pause_p, 5 ticks → still 01:01, running=0.
- Preload 99:59 in RUN, one tick_1hz → 00:00 on the next cycle.
- adj=1, sel=1 at 00:58, 3 tick_2hz → 00:01 with no minute carry. blank toggles 0011/0000 on each tick_2hz. adj=0 → PAUSE, blank=0000.
- pause_p and tick_1hz in the same cycle in RUN at 00:10 → 00:11, running=0. clr_p and tick_1hz together → 00:00.
- rst asserted at 12:34 in RUN → next cycle 00:00, PAUSE, blank=0000, running=0.
- STOPWATCH_LAP_EN: lap_p at 00:05, 10 ticks → display holds 00:05. Second lap_p → display shows 00:15.
